// File: rtl/ram_access_ctrl.sv
// Request/response front-end and bulk-clear sequencer for a single-port synchronous RAM.
// Optional access counters are enabled by defining RAM_ACCESS_CTRL_STATS_EN.
module ram_access_ctrl #(
  parameter int unsigned    AW        = 6,
  parameter int unsigned    DW        = 8,
  parameter int unsigned    RD_LAT    = 1,
  parameter logic [DW-1:0]  CLEAR_VAL = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  input  logic          clear_start,
  output logic          clear_busy,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
`ifdef RAM_ACCESS_CTRL_STATS_EN
  ,
  output logic [15:0]   wr_count,
  output logic [15:0]   rd_count
`endif
);

  // Clear counter carries one extra bit so the terminal count 2**AW is exact.
  localparam int unsigned   CW       = AW + 1;
  localparam logic [CW-1:0] LAST_CNT = {1'b1, {AW{1'b0}}};
  // Read tag stages: one for the RAM address cycle plus RD_LAT for the RAM latency.
  localparam int unsigned   PD       = RD_LAT + 1;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_CLEAR = 1'b1;

  logic [0:0]    state;
  logic [0:0]    state_nxt;
  logic [CW-1:0] clr_cnt;
  logic [CW-1:0] clr_cnt_nxt;
  logic          clear_busy_nxt;
  logic          ram_we_nxt;
  logic [AW-1:0] ram_addr_nxt;
  logic [DW-1:0] ram_din_nxt;
  logic [PD-1:0] rd_pipe;
  logic [PD-1:0] rd_pipe_nxt;
  logic          accept_c;
  logic          rd_issue_c;

  assign req_ready  = rst_n && (state == S_IDLE) && !clear_start;
  assign accept_c   = req_valid && req_ready;
  assign rd_issue_c = accept_c && !req_we;

  // Next-state and RAM port decode.
  always_comb begin
    state_nxt      = state;
    clr_cnt_nxt    = clr_cnt;
    clear_busy_nxt = clear_busy;
    ram_we_nxt     = 1'b0;
    ram_addr_nxt   = ram_addr;
    ram_din_nxt    = ram_din;
    case (state)
      S_IDLE: begin
        if (clear_start) begin
          state_nxt      = S_CLEAR;
          clear_busy_nxt = 1'b1;
          ram_we_nxt     = 1'b1;
          ram_addr_nxt   = '0;
          ram_din_nxt    = CLEAR_VAL;
          clr_cnt_nxt    = CW'(1);
        end else if (accept_c) begin
          ram_we_nxt   = req_we;
          ram_addr_nxt = req_addr;
          if (req_we) begin
            ram_din_nxt = req_wdata;
          end
        end
      end
      S_CLEAR: begin
        if (clr_cnt == LAST_CNT) begin
          state_nxt      = S_IDLE;
          clear_busy_nxt = 1'b0;
          clr_cnt_nxt    = '0;
        end else begin
          ram_we_nxt   = 1'b1;
          ram_addr_nxt = clr_cnt[AW-1:0];
          ram_din_nxt  = CLEAR_VAL;
          clr_cnt_nxt  = clr_cnt + CW'(1);
        end
      end
      default: begin
        state_nxt      = S_IDLE;
        clear_busy_nxt = 1'b0;
        clr_cnt_nxt    = '0;
      end
    endcase
  end

  // Read tags shift once per cycle; the oldest stage marks valid ram_dout.
  always_comb begin
    rd_pipe_nxt = {rd_pipe[PD-2:0], rd_issue_c};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      clr_cnt    <= '0;
      clear_busy <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_din    <= '0;
      rd_pipe    <= '0;
    end else begin
      state      <= state_nxt;
      clr_cnt    <= clr_cnt_nxt;
      clear_busy <= clear_busy_nxt;
      ram_we     <= ram_we_nxt;
      ram_addr   <= ram_addr_nxt;
      ram_din    <= ram_din_nxt;
      rd_pipe    <= rd_pipe_nxt;
    end
  end

  // Response capture; rsp_rdata holds between strobes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= rd_pipe[PD-1];
      if (rd_pipe[PD-1]) begin
        rsp_rdata <= ram_dout;
      end
    end
  end

`ifdef RAM_ACCESS_CTRL_STATS_EN
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  // Saturating counters of accepted requests; clear writes never pass through accept_c.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_count <= '0;
      rd_count <= '0;
    end else if (clear_start) begin
      wr_count <= '0;
      rd_count <= '0;
    end else if (accept_c) begin
      if (req_we) begin
        if (wr_count != CNT_MAX) begin
          wr_count <= wr_count + 16'd1;
        end
      end else if (rd_count != CNT_MAX) begin
        rd_count <= rd_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Self-checking bench for ram_access_ctrl: behavioural RAM, transaction-level reference
// model, directed scenarios and randomized traffic.
module tb_ram_access_ctrl;

  localparam int unsigned AW     = 6;
  localparam int unsigned DW     = 8;
  localparam int unsigned RD_LAT = 1;
  localparam int          DEPTH  = 64;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          clear_start;
  logic          clear_busy;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;
`ifdef RAM_ACCESS_CTRL_STATS_EN
  logic [15:0]   wr_count;
  logic [15:0]   rd_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  ram_access_ctrl #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .CLEAR_VAL(8'h00)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .clear_start(clear_start), .clear_busy(clear_busy),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
`ifdef RAM_ACCESS_CTRL_STATS_EN
    , .wr_count(wr_count), .rd_count(rd_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port RAM with RD_LAT cycles of read latency.
  logic [DW-1:0] ram_mem [DEPTH];
  logic [DW-1:0] rd_q1, rd_q2;
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_din;
    rd_q1 <= ram_mem[ram_addr];
    rd_q2 <= rd_q1;
  end
  assign ram_dout = (RD_LAT == 2) ? rd_q2 : rd_q1;

  // Transaction-level reference: memory image, clear countdown, due-cycle response queue.
  typedef struct { int due; logic [DW-1:0] data; } rsp_t;
  rsp_t          exp_q[$];
  rsp_t          new_rsp;
  logic [DW-1:0] ref_mem [DEPTH];
  int            cyc        = 0;
  int            clear_left = 0;
  logic          exp_valid  = 1'b0;
  logic [DW-1:0] exp_rdata  = '0;
  logic          m_acc;
  int            mdl_wr = 0;
  int            mdl_rd = 0;

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      exp_valid  = 1'b0;
      exp_rdata  = '0;
      clear_left = 0;
      mdl_wr     = 0;
      mdl_rd     = 0;
    end else begin
      m_acc     = req_valid && (clear_left == 0) && !clear_start;
      exp_valid = 1'b0;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        exp_valid = 1'b1;
        exp_rdata = exp_q[0].data;
        void'(exp_q.pop_front());
      end
      if (clear_left > 0) clear_left--;
      else if (clear_start) begin
        clear_left = DEPTH;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
      end
      if (clear_start) begin
        mdl_wr = 0;
        mdl_rd = 0;
      end
      if (m_acc) begin
        if (req_we) begin
          ref_mem[req_addr] = req_wdata;
          if (mdl_wr < 65535) mdl_wr++;
        end else begin
          new_rsp.due  = cyc + RD_LAT + 1;
          new_rsp.data = ref_mem[req_addr];
          exp_q.push_back(new_rsp);
          if (mdl_rd < 65535) mdl_rd++;
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid = v;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    clear_start = 1'b0;
    drive_req(1'b1, 1'b0, 6'd0, 8'h00);
    repeat (3) tick();
    n_tests++;
    if ({req_ready, rsp_valid, clear_busy, ram_we} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: ready/rspv/busy/we=%b expected 0000", {req_ready, rsp_valid, clear_busy, ram_we});
    end
    n_tests++;
    if (ram_addr !== 6'd0 || ram_din !== 8'h00 || rsp_rdata !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_data: addr=%h din=%h rdata=%h expected 0 0 0", ram_addr, ram_din, rsp_rdata);
    end
    req_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready_after: req_ready=%b expected 1", req_ready);
    end
    tick();
  endtask

  task automatic test_directed_rw;
    logic          we_s [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [AW-1:0] a_s  [6] = '{6'd0, 6'd1, 6'd2, 6'd0, 6'd1, 6'd2};
    logic [DW-1:0] d_s  [6] = '{8'h01, 8'h02, 8'h03, 8'h00, 8'h00, 8'h00};
    logic [DW-1:0] want [3] = '{8'h01, 8'h02, 8'h03};
    logic [DW-1:0] got[$];
    int            idx[$];
    int            t = 0;
    for (int i = 0; i < 6; i++) begin
      drive_req(1'b1, we_s[i], a_s[i], d_s[i]);
      #1;
      n_tests++;
      if (req_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL rw_ready[%0d]: req_ready=%b expected 1", i, req_ready);
      end
      tick(); t++;
      n_tests++;
      if (ram_we !== we_s[i] || ram_addr !== a_s[i] || (we_s[i] && ram_din !== d_s[i])) begin
        n_fail++;
        $display("FAIL rw_ramport[%0d]: we=%b addr=%h din=%h expected %b %h %h", i, ram_we, ram_addr, ram_din, we_s[i], a_s[i], d_s[i]);
      end
      n_tests++;
      if (rsp_valid !== exp_valid || rsp_rdata !== exp_rdata) begin
        n_fail++;
        $display("FAIL rw_rsp: valid=%b data=%h expected %b %h", rsp_valid, rsp_rdata, exp_valid, exp_rdata);
      end
      if (rsp_valid === 1'b1) begin got.push_back(rsp_rdata); idx.push_back(t); end
    end
    req_valid = 1'b0;
    for (int i = 0; i < RD_LAT + 4; i++) begin
      tick(); t++;
      n_tests++;
      if (rsp_valid !== exp_valid || rsp_rdata !== exp_rdata) begin
        n_fail++;
        $display("FAIL rw_rsp_drain: valid=%b data=%h expected %b %h", rsp_valid, rsp_rdata, exp_valid, exp_rdata);
      end
      if (rsp_valid === 1'b1) begin got.push_back(rsp_rdata); idx.push_back(t); end
      if (i == 0) begin
        n_tests++;
        if (ram_we !== 1'b0 || ram_addr !== 6'd2) begin
          n_fail++;
          $display("FAIL rw_idle_port: we=%b addr=%h expected 0 02", ram_we, ram_addr);
        end
      end
    end
    n_tests++;
    if (got.size() != 3) begin
      n_fail++;
      $display("FAIL rw_rsp_count: got %0d responses expected 3", got.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_tests++;
        if (got[i] !== want[i]) begin
          n_fail++;
          $display("FAIL rw_rsp_data[%0d]: %h expected %h", i, got[i], want[i]);
        end
      end
      n_tests++;
      if (idx[0] != 5 + RD_LAT || idx[2] - idx[0] != 2) begin
        n_fail++;
        $display("FAIL rw_rsp_timing: first=%0d last=%0d expected %0d %0d", idx[0], idx[2], 5 + RD_LAT, 7 + RD_LAT);
      end
    end
  endtask

  task automatic test_write_then_read;
    logic [DW-1:0] got[$];
    drive_req(1'b1, 1'b1, 6'd1, 8'h04);
    tick();
    drive_req(1'b1, 1'b0, 6'd1, 8'h00);
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < RD_LAT + 3; i++) begin
      tick();
      n_tests++;
      if (rsp_valid !== exp_valid || rsp_rdata !== exp_rdata) begin
        n_fail++;
        $display("FAIL wr_rd_rsp: valid=%b data=%h expected %b %h", rsp_valid, rsp_rdata, exp_valid, exp_rdata);
      end
      if (rsp_valid === 1'b1) got.push_back(rsp_rdata);
    end
    n_tests++;
    if (got.size() != 1 || got[0] !== 8'h04) begin
      n_fail++;
      $display("FAIL wr_rd_data: %0d responses, first=%h expected one of 04", got.size(), (got.size() > 0) ? got[0] : 8'hxx);
    end
  endtask

  task automatic test_clear;
    logic [DW-1:0] got[$];
    drive_req(1'b1, 1'b0, 6'd2, 8'h00);
    tick();
    req_valid = 1'b0;
    clear_start = 1'b1;
    #1;
    n_tests++;
    if (req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_start_ready: req_ready=%b expected 0", req_ready);
    end
    tick();
    clear_start = 1'b0;
    drive_req(1'b1, 1'b0, 6'd0, 8'h00);
    for (int k = 0; k < DEPTH; k++) begin
      n_tests++;
      if (clear_busy !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 6'(k) || ram_din !== 8'h00) begin
        n_fail++;
        $display("FAIL clr_sweep[%0d]: busy=%b we=%b addr=%h din=%h expected 1 1 %h 00", k, clear_busy, ram_we, ram_addr, ram_din, 6'(k));
      end
      n_tests++;
      if (rsp_valid !== exp_valid || rsp_rdata !== exp_rdata) begin
        n_fail++;
        $display("FAIL clr_inflight_rsp: valid=%b data=%h expected %b %h", rsp_valid, rsp_rdata, exp_valid, exp_rdata);
      end
      clear_start = (k == 20);
      #1;
      n_tests++;
      if (req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL clr_ready[%0d]: req_ready=%b expected 0", k, req_ready);
      end
      tick();
    end
    clear_start = 1'b0;
    n_tests++;
    if (clear_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_busy_len: clear_busy=%b after 64 cycles expected 0", clear_busy);
    end
    #1;
    n_tests++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_held_ready: req_ready=%b expected 1", req_ready);
    end
    tick();
    n_tests++;
    if (ram_we !== 1'b0 || ram_addr !== 6'd0) begin
      n_fail++;
      $display("FAIL clr_held_accept: we=%b addr=%h expected 0 00", ram_we, ram_addr);
    end
    if (rsp_valid === 1'b1) got.push_back(rsp_rdata);
    drive_req(1'b1, 1'b0, 6'd1, 8'h00);
    tick();
    if (rsp_valid === 1'b1) got.push_back(rsp_rdata);
    drive_req(1'b1, 1'b0, 6'd63, 8'h00);
    tick();
    if (rsp_valid === 1'b1) got.push_back(rsp_rdata);
    req_valid = 1'b0;
    for (int i = 0; i < RD_LAT + 3; i++) begin
      tick();
      n_tests++;
      if (rsp_valid !== exp_valid || rsp_rdata !== exp_rdata) begin
        n_fail++;
        $display("FAIL clr_read_rsp: valid=%b data=%h expected %b %h", rsp_valid, rsp_rdata, exp_valid, exp_rdata);
      end
      if (rsp_valid === 1'b1) got.push_back(rsp_rdata);
    end
    n_tests++;
    if (got.size() != 3 || got[0] !== 8'h00 || got[1] !== 8'h00 || got[2] !== 8'h00) begin
      n_fail++;
      $display("FAIL clr_read_data: %0d responses expected 3 of 00", got.size());
    end
  endtask

  task automatic test_collision;
    logic [DW-1:0] got[$];
    int n = 0;
    drive_req(1'b1, 1'b1, 6'd5, 8'hAA);
    clear_start = 1'b1;
    #1;
    n_tests++;
    if (req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL coll_ready: req_ready=%b expected 0", req_ready);
    end
    tick();
    clear_start = 1'b0;
    while (clear_busy === 1'b1 && n < 100) begin
      n_tests++;
      if (ram_addr !== 6'(n) || ram_din !== 8'h00) begin
        n_fail++;
        $display("FAIL coll_sweep[%0d]: addr=%h din=%h expected %h 00", n, ram_addr, ram_din, 6'(n));
      end
      tick();
      n++;
    end
    n_tests++;
    if (n != DEPTH) begin
      n_fail++;
      $display("FAIL coll_busy_len: clear_busy high %0d cycles expected 64", n);
    end
    #1;
    n_tests++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL coll_ready_after: req_ready=%b expected 1", req_ready);
    end
    tick();
    n_tests++;
    if (ram_we !== 1'b1 || ram_addr !== 6'd5 || ram_din !== 8'hAA) begin
      n_fail++;
      $display("FAIL coll_write: we=%b addr=%h din=%h expected 1 05 aa", ram_we, ram_addr, ram_din);
    end
    drive_req(1'b1, 1'b0, 6'd5, 8'h00);
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < RD_LAT + 3; i++) begin
      tick();
      n_tests++;
      if (rsp_valid !== exp_valid || rsp_rdata !== exp_rdata) begin
        n_fail++;
        $display("FAIL coll_rsp: valid=%b data=%h expected %b %h", rsp_valid, rsp_rdata, exp_valid, exp_rdata);
      end
      if (rsp_valid === 1'b1) got.push_back(rsp_rdata);
    end
    n_tests++;
    if (got.size() != 1 || got[0] !== 8'hAA) begin
      n_fail++;
      $display("FAIL coll_read_data: %0d responses expected one of aa", got.size());
    end
  endtask

  task automatic test_random;
    logic          acc_prev = 1'b0;
    logic          we_prev  = 1'b0;
    logic [AW-1:0] a_prev   = '0;
    logic [DW-1:0] d_prev   = '0;
    logic          exp_rdy;
    for (int i = 0; i < 500; i++) begin
      n_tests++;
      if (rsp_valid !== exp_valid || rsp_rdata !== exp_rdata) begin
        n_fail++;
        $display("FAIL rnd_rsp[%0d]: valid=%b data=%h expected %b %h", i, rsp_valid, rsp_rdata, exp_valid, exp_rdata);
      end
      n_tests++;
      if (clear_busy !== (clear_left > 0)) begin
        n_fail++;
        $display("FAIL rnd_busy[%0d]: clear_busy=%b expected %b", i, clear_busy, clear_left > 0);
      end
      if (acc_prev) begin
        n_tests++;
        if (ram_we !== we_prev || ram_addr !== a_prev || (we_prev && ram_din !== d_prev)) begin
          n_fail++;
          $display("FAIL rnd_port[%0d]: we=%b addr=%h din=%h expected %b %h %h", i, ram_we, ram_addr, ram_din, we_prev, a_prev, d_prev);
        end
      end
      drive_req($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), 8'($urandom));
      clear_start = ($urandom_range(0, 249) == 0);
      #1;
      exp_rdy = rst_n && (clear_left == 0) && !clear_start;
      n_tests++;
      if (req_ready !== exp_rdy) begin
        n_fail++;
        $display("FAIL rnd_ready[%0d]: req_ready=%b expected %b", i, req_ready, exp_rdy);
      end
      acc_prev = req_valid && exp_rdy;
      we_prev  = req_we;
      a_prev   = req_addr;
      d_prev   = req_wdata;
      tick();
    end
    req_valid   = 1'b0;
    clear_start = 1'b0;
    for (int i = 0; i < 80 && (clear_busy === 1'b1 || exp_q.size() > 0 || i < RD_LAT + 2); i++) begin
      n_tests++;
      if (rsp_valid !== exp_valid || rsp_rdata !== exp_rdata) begin
        n_fail++;
        $display("FAIL rnd_drain: valid=%b data=%h expected %b %h", rsp_valid, rsp_rdata, exp_valid, exp_rdata);
      end
      tick();
    end
    n_tests++;
    if (clear_busy !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rnd_settle: clear_busy=%b pending=%0d expected 0 0", clear_busy, exp_q.size());
    end
  endtask

`ifdef RAM_ACCESS_CTRL_STATS_EN
  task automatic test_stats;
    logic          we_s [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [AW-1:0] a_s  [8] = '{6'd10, 6'd11, 6'd12, 6'd10, 6'd11, 6'd12, 6'd13, 6'd14};
    int n = 0;
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    while (clear_busy === 1'b1 && n < 100) begin tick(); n++; end
    for (int i = 0; i < 8; i++) begin
      drive_req(1'b1, we_s[i], a_s[i], 8'(i + 8'h30));
      tick();
    end
    req_valid = 1'b0;
    repeat (RD_LAT + 2) tick();
    n_tests++;
    if (wr_count !== 16'd3 || rd_count !== 16'd5) begin
      n_fail++;
      $display("FAIL stats_count: wr=%0d rd=%0d expected 3 5", wr_count, rd_count);
    end
    n_tests++;
    if (wr_count !== 16'(mdl_wr) || rd_count !== 16'(mdl_rd)) begin
      n_fail++;
      $display("FAIL stats_model: wr=%0d rd=%0d expected %0d %0d", wr_count, rd_count, mdl_wr, mdl_rd);
    end
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    n_tests++;
    if (wr_count !== 16'd0 || rd_count !== 16'd0) begin
      n_fail++;
      $display("FAIL stats_clear: wr=%0d rd=%0d expected 0 0", wr_count, rd_count);
    end
    n = 0;
    while (clear_busy === 1'b1 && n < 100) begin tick(); n++; end
  endtask
`endif

  task automatic test_reset_midop;
    int n = 0;
    drive_req(1'b1, 1'b1, 6'd2, 8'h03);
    tick();
    drive_req(1'b1, 1'b0, 6'd2, 8'h00);
    tick();
    req_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    n_tests++;
    if ({rsp_valid, clear_busy, ram_we, req_ready} !== 4'b0000 || rsp_rdata !== 8'h00 || ram_addr !== 6'd0 || ram_din !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_read_outputs: rspv=%b busy=%b we=%b rdy=%b rdata=%h addr=%h din=%h expected all 0",
               rsp_valid, clear_busy, ram_we, req_ready, rsp_rdata, ram_addr, ram_din);
    end
    rst_n = 1'b1;
    for (int i = 0; i < RD_LAT + 3; i++) begin
      tick();
      n_tests++;
      if (rsp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_read_dropped: rsp_valid=%b expected 0", rsp_valid);
      end
    end
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    while (n < 10) begin tick(); n++; end
    rst_n = 1'b0;
    tick();
    n_tests++;
    if (clear_busy !== 1'b0 || ram_we !== 1'b0 || ram_addr !== 6'd0) begin
      n_fail++;
      $display("FAIL rst_clear_abort: busy=%b we=%b addr=%h expected 0 0 00", clear_busy, ram_we, ram_addr);
    end
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_clear_ready: req_ready=%b expected 1", req_ready);
    end
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    clear_start = 1'b0;
    drive_req(1'b0, 1'b0, '0, '0);
    test_reset();
    test_directed_rw();
    test_write_then_read();
    test_clear();
    test_collision();
    test_random();
`ifdef RAM_ACCESS_CTRL_STATS_EN
    test_stats();
`endif
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_access_ctrl.md
Name: ram_access_ctrl

Overview:
- Upstream front-end for the 64x8 single-port RAM; owns the RAM's we/addr/data_in pins and samples its data_out.
- Converts a valid/ready request stream (single reads/writes) into RAM port cycles and returns read data with a valid strobe.
- Provides a hardware bulk-clear sequencer that writes CLEAR_VAL to every location, so software never has to walk the array.

Parameters:
- AW, 6, RAM address width; depth = 2**AW.
- DW, 8, RAM data width.
- RD_LAT, 1, cycles from address presented (ram_we=0) to valid ram_dout; legal values 1 or 2.
- CLEAR_VAL, 8'h00, value written by bulk clear.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when valid&ready
- req_we  in  1  1 = write, 0 = read
- req_addr  in  AW  request address
- req_wdata  in  DW  write data
- rsp_valid  out  1  one-cycle pulse, read data valid
- rsp_rdata  out  DW  read data; held until next rsp_valid
- clear_start  in  1  pulse: begin bulk clear
- clear_busy  out  1  high while clear in progress
- ram_we  out  1  to RAM we
- ram_addr  out  AW  to RAM addr
- ram_din  out  DW  to RAM data_in
- ram_dout  in  DW  from RAM data_out

Behaviour:
- Interface decision: one clock, clk; reset is synchronous and active-low, rst_n, sampled on rising clk.
- Reset values: req_ready=0 during reset and 1 in the first cycle after it; rsp_valid=0; rsp_rdata=0; clear_busy=0; ram_we=0; ram_addr=0; ram_din=0; the read-tag pipeline is cleared.
- FSM states:
  - IDLE -> CLEAR on clear_start.
  - CLEAR -> IDLE after the last address (2**AW-1) is written.
- req_ready = (state==IDLE) && !clear_start. It is combinational and does not depend on req_valid.
- Accepted request (IDLE, valid&ready) at edge N: ram_we/ram_addr/ram_din are registered and drive the RAM in cycle N+1. Only one request is issued per cycle; back-to-back requests run at full throughput.
- Write: ram_we=1 for exactly one cycle and produces no response.
- Read: ram_we=0 and a tag enters an RD_LAT-deep valid pipeline. rsp_valid pulses exactly RD_LAT cycles after the RAM address cycle, and rsp_rdata captures ram_dout on that edge. Responses return in issue order.
- Cycles with no request: ram_we=0; ram_addr holds its last value.
- CLEAR:
  - ram_we=1 and ram_din=CLEAR_VAL.
  - ram_addr steps 0,1,...,2**AW-1, one per cycle, for exactly 2**AW cycles.
  - clear_busy is high from the cycle after clear_start through the last write cycle; req_ready is 0 throughout.
- clear_start while already in CLEAR is ignored; the sequence does not restart.
- clear_start and req_valid in the same cycle: clear wins and the request is not accepted (req_ready=0). The requester must hold the request.
- Reads already in flight when clear starts still complete, with data from their original address, before or during the clear.
- Write then read of the same address in consecutive accepted cycles returns the new data; the RAM write completes before the read cycle.
- Address wrap: clear counter is AW+1 bits internally so termination is exact. Request addresses use no arithmetic.
- rst_n low mid-clear or mid-read: the clear is aborted immediately; pending responses are dropped (no rsp_valid); memory contents are undefined for the partially cleared range.

Optional Feature:
- Macro: RAM_ACCESS_CTRL_STATS_EN.
- Defined: adds outputs wr_count[15:0] and rd_count[15:0].
  - They count accepted write and read requests; clear writes are excluded.
  - Both saturate at 16'hFFFF, reset to 0, and are cleared by clear_start.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then write 8'h01@0, 8'h02@1, 8'h03@2 back-to-back, then read 0,1,2 -> req_ready stays 1; rsp_valid pulses 3 consecutive cycles with rsp_rdata 01,02,03 (RD_LAT=1 and RD_LAT=2 builds).
- Write 8'h04@1, then read 1 on the next cycle -> rsp_rdata=8'h04 RD_LAT cycles after the read's RAM cycle.
- Pulse clear_start, then read 0,1,63 once clear_busy falls -> clear_busy high for exactly 64 cycles, ram_addr sweeps 0..63 with ram_we=1, all reads return 8'h00; a request held valid during the clear is accepted the cycle after clear_busy drops.
- clear_start and req_valid (write 8'hAA@5) in the same cycle -> request not accepted; after the clear it is accepted; read 5 returns 8'hAA.
- Issue read@2 (data 8'h03), assert rst_n=0 on the next cycle -> no rsp_valid; all outputs at reset values the cycle after the reset edge.
- STATS_EN build: 3 writes and 5 reads -> wr_count=3, rd_count=5; clear_start -> both 0.
